// File: rtl/wallace_multiplier_pipe.sv
// Three-stage pipelined Wallace-tree multiplier (unsigned / two's complement per operand pair).
// Optional accumulate mode under WALLACE_MULTIPLIER_PIPE_ACC_EN; one global stall holds all stages.
module wallace_multiplier_pipe #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 sgn,
`ifdef WALLACE_MULTIPLIER_PIPE_ACC_EN
    input  logic                 acc_en,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    localparam int PW     = 2 * WIDTH;
    localparam int NR     = WIDTH + 1;   // WIDTH partial-product rows plus the correction row
    localparam int LEVELS = 8;           // 3:2 levels needed to bring 33 rows down to 2

    logic          stall, adv, accept;
    logic          s1_vld_q, s1_vld_d;
    logic [PW-1:0] pp_q [NR];
    logic [PW-1:0] pp_d [NR];
    logic          s2_vld_q, s2_vld_d;
    logic [PW-1:0] row0_q, row0_d, row1_q, row1_d;
    logic          out_vld_q, out_vld_d;
    logic [PW-1:0] product_q, product_d;
`ifdef WALLACE_MULTIPLIER_PIPE_ACC_EN
    logic          s1_acc_q, s1_acc_d, s2_acc_q, s2_acc_d;
`endif

    assign stall     = out_vld_q & ~out_ready;
    assign adv       = ~stall;
    assign in_ready  = adv;
    assign accept    = in_valid & adv;
    assign out_valid = out_vld_q;
    assign product   = product_q;

    // S1: Baugh-Wooley inverts bits where exactly one index is the sign position,
    // then adds 2^WIDTH + 2^(2*WIDTH-1) to fix up the signed weighting.
    always_comb begin : s1_comb
        logic [PW-1:0] row;
        row      = '0;
        s1_vld_d = adv ? in_valid : s1_vld_q;
        pp_d     = pp_q;
`ifdef WALLACE_MULTIPLIER_PIPE_ACC_EN
        s1_acc_d = accept ? acc_en : s1_acc_q;
`endif
        if (accept) begin
            for (int i = 0; i < WIDTH; i++) begin
                row = '0;
                for (int j = 0; j < WIDTH; j++) begin
                    row[i+j] = (a[j] & b[i]) ^ (sgn & ((i == WIDTH-1) ^ (j == WIDTH-1)));
                end
                pp_d[i] = row;
            end
            pp_d[WIDTH] = sgn ? ((PW'(1) << WIDTH) | (PW'(1) << (PW-1))) : '0;
        end
    end

    // S2: row-wise 3:2 compression per level until two rows remain.
    always_comb begin : s2_comb
        logic [PW-1:0] lvl [NR];
        logic [PW-1:0] nxt [NR];
        int n, m;
        lvl = pp_q;
        nxt = '{default: '0};
        n   = NR;
        m   = 0;
        for (int l = 0; l < LEVELS; l++) begin
            if (n > 2) begin
                nxt = '{default: '0};
                m   = 0;
                for (int k = 0; k < NR; k += 3) begin
                    if (k + 2 < n) begin
                        nxt[m]   = lvl[k] ^ lvl[k+1] ^ lvl[k+2];
                        nxt[m+1] = ((lvl[k] & lvl[k+1]) | (lvl[k] & lvl[k+2]) |
                                    (lvl[k+1] & lvl[k+2])) << 1;
                        m = m + 2;
                    end else begin
                        if (k < n) begin
                            nxt[m] = lvl[k];
                            m = m + 1;
                        end
                        if (k + 1 < n) begin
                            nxt[m] = lvl[k+1];
                            m = m + 1;
                        end
                    end
                end
                lvl = nxt;
                n   = m;
            end
        end
        s2_vld_d = adv ? s1_vld_q : s2_vld_q;
        row0_d   = row0_q;
        row1_d   = row1_q;
`ifdef WALLACE_MULTIPLIER_PIPE_ACC_EN
        s2_acc_d = (adv && s1_vld_q) ? s1_acc_q : s2_acc_q;
`endif
        if (adv && s1_vld_q) begin
            row0_d = lvl[0];
            row1_d = lvl[1];
        end
    end

    // S3: product only changes when a real result arrives, so it also serves as the accumulator.
    always_comb begin : s3_comb
        out_vld_d = adv ? s2_vld_q : out_vld_q;
        product_d = product_q;
        if (adv && s2_vld_q) begin
`ifdef WALLACE_MULTIPLIER_PIPE_ACC_EN
            product_d = row0_q + row1_q + (s2_acc_q ? product_q : '0);
`else
            product_d = row0_q + row1_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            pp_q      <= '{default: '0};
            s2_vld_q  <= 1'b0;
            row0_q    <= '0;
            row1_q    <= '0;
            out_vld_q <= 1'b0;
            product_q <= '0;
`ifdef WALLACE_MULTIPLIER_PIPE_ACC_EN
            s1_acc_q  <= 1'b0;
            s2_acc_q  <= 1'b0;
`endif
        end else begin
            s1_vld_q  <= s1_vld_d;
            pp_q      <= pp_d;
            s2_vld_q  <= s2_vld_d;
            row0_q    <= row0_d;
            row1_q    <= row1_d;
            out_vld_q <= out_vld_d;
            product_q <= product_d;
`ifdef WALLACE_MULTIPLIER_PIPE_ACC_EN
            s1_acc_q  <= s1_acc_d;
            s2_acc_q  <= s2_acc_d;
`endif
        end
    end

endmodule
